// File: rtl/ym2149_pkg.sv
// ============================================================================
// Module  : ym2149_pkg
// Brief   : Shared constants for the YM2149 bus master: FSM states, BDIR/BC1
//           encodings, chip-select codes and default phase timings.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ym2149_pkg;

    typedef logic [2:0] ym_state_t;

    localparam ym_state_t c_ST_IDLE  = 3'd0;
    localparam ym_state_t c_ST_ADDR  = 3'd1;
    localparam ym_state_t c_ST_GAP   = 3'd2;
    localparam ym_state_t c_ST_WDATA = 3'd3;
    localparam ym_state_t c_ST_RDATA = 3'd4;
    localparam ym_state_t c_ST_DONE  = 3'd5;

    // Bus encodings packed as {bdir, bc1}
    typedef logic [1:0] ym_bus_t;

    localparam ym_bus_t c_BUS_INACTIVE = 2'b00;
    localparam ym_bus_t c_BUS_LATCH    = 2'b11;
    localparam ym_bus_t c_BUS_WRITE    = 2'b10;
    localparam ym_bus_t c_BUS_READ     = 2'b01;

    localparam logic [1:0] c_A8_CHIP0 = 2'b10;
    localparam logic [1:0] c_A8_CHIP1 = 2'b01;

    localparam int c_T_ADDR_DEF = 2;
    localparam int c_T_WR_DEF   = 2;
    localparam int c_T_RD_DEF   = 3;

    function automatic logic [1:0] a8_sel(input logic chip);
        return chip ? c_A8_CHIP1 : c_A8_CHIP0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ym_phase_timer.sv
// ============================================================================
// Module  : ym_phase_timer
// Brief   : 4-bit loadable down-counter; o_done flags the final cycle of a phase.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ym_phase_timer (
    input  logic       clk350,
    input  logic       reset,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    output logic       o_done
);

    logic [3:0] r_count;

    always_ff @(posedge clk350 or negedge reset) begin
        if (!reset) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
        end
    end

    // Count 1 is the last cycle of the loaded phase, so the FSM advances on it.
    assign o_done = (r_count == 4'd1);

endmodule

`default_nettype wire

// File: rtl/ym2149_bus_master.sv
// ============================================================================
// Module  : ym2149_bus_master
// Brief   : Sequences YM2149 register read/write cycles (latch, gap, data, done)
//           on the BDIR/BC1/DA bus for one of two chips.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ym2149_bus_master
    import ym2149_pkg::*;
#(
    parameter int T_ADDR = c_T_ADDR_DEF,
    parameter int T_WR   = c_T_WR_DEF,
    parameter int T_RD   = c_T_RD_DEF
) (
    input  logic       clk350,
    input  logic       reset,
    input  logic       req,
    input  logic       chip,
    input  logic       rd,
    input  logic [3:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       ack,
    output logic [7:0] rdata,
    output logic       bdir,
    output logic       bc1,
    output logic [1:0] a8,
    output logic [7:0] da_out,
    output logic       da_oe,
    input  logic [7:0] da_in
);

    localparam logic [3:0] c_LD_ADDR = 4'(T_ADDR);
    localparam logic [3:0] c_LD_WR   = 4'(T_WR);
    localparam logic [3:0] c_LD_RD   = 4'(T_RD);

    ym_state_t   r_state;
    ym_state_t   w_next;
    logic        r_rd;
    logic [3:0]  r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_rdata;
    logic [1:0]  r_a8;
    logic        w_load;
    logic [3:0]  w_load_val;
    logic        w_done;
    ym_bus_t     w_bus;

    ym_phase_timer u_timer (
        .clk350     (clk350),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_done)
    );

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = c_LD_ADDR;
        case (r_state)
            c_ST_IDLE: begin
                if (req) begin
                    w_next = c_ST_ADDR;
                    w_load = 1'b1;
                end
            end
            c_ST_ADDR:  if (w_done) w_next = c_ST_GAP;
            c_ST_GAP: begin
                w_next     = r_rd ? c_ST_RDATA : c_ST_WDATA;
                w_load     = 1'b1;
                w_load_val = r_rd ? c_LD_RD : c_LD_WR;
            end
            c_ST_WDATA: if (w_done) w_next = c_ST_DONE;
            c_ST_RDATA: if (w_done) w_next = c_ST_DONE;
            c_ST_DONE:  w_next = c_ST_IDLE;
            default:    w_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk350 or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
            r_rd    <= 1'b0;
            r_addr  <= 4'd0;
            r_wdata <= 8'd0;
            r_rdata <= 8'd0;
            r_a8    <= c_A8_CHIP0;
        end else begin
            r_state <= w_next;
            if (r_state == c_ST_IDLE && req) begin
                r_rd    <= rd;
                r_addr  <= addr;
                r_wdata <= wdata;
                r_a8    <= a8_sel(chip);
            end
            if (r_state == c_ST_RDATA && w_done) begin
                r_rdata <= da_in;
            end
        end
    end

    // Bus pins decode from state only, so an asynchronous reset idles them at once.
    always_comb begin
        w_bus  = c_BUS_INACTIVE;
        da_out = 8'd0;
        da_oe  = 1'b0;
        case (r_state)
            c_ST_ADDR: begin
                w_bus  = c_BUS_LATCH;
                da_out = {4'h0, r_addr};
                da_oe  = 1'b1;
            end
            c_ST_WDATA: begin
                w_bus  = c_BUS_WRITE;
                da_out = r_wdata;
                da_oe  = 1'b1;
            end
            c_ST_RDATA: w_bus = c_BUS_READ;
            default:    w_bus = c_BUS_INACTIVE;
        endcase
    end

    assign bdir  = w_bus[1];
    assign bc1   = w_bus[0];
    assign busy  = (r_state != c_ST_IDLE);
    assign ack   = (r_state == c_ST_DONE);
    assign rdata = r_rdata;
    assign a8    = r_a8;

endmodule

`default_nettype wire
